// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM duty ramp: FSM state encoding, default
// parameter constants and the counter-width helper.
package pwm_ramp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int DEF_PERIOD_TICKS = 200;
    localparam int DEF_DUTY_W       = 8;
    localparam int DEF_RAMP_STEP    = 1;

    // Bits needed to hold 0 .. max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < max_count) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pwm_ramp_if.sv
// Target-duty request channel: valid/duty from the requester, ready back
// from the ramp block.
interface pwm_ramp_if
    import pwm_ramp_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W
) ();

    logic              req_valid;
    logic [DUTY_W-1:0] req_duty;
    logic              req_ready;

    modport master (
        output req_valid,
        output req_duty,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_duty,
        output req_ready
    );

endinterface

// File: rtl/pwm_ramp.sv
// PWM generator whose duty slews toward a requested target by a bounded
// step per period, changing duty only at period boundaries.
module pwm_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    pwm_ramp_if.slave  bus,
    output logic       pwm,
    output logic       at_target
);

    localparam int                CNT_W    = cnt_width(PERIOD_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD_TICKS);
    // A step wider than the period can never be used in full.
    localparam int                STEP_SAT = (RAMP_STEP > PERIOD_TICKS) ? PERIOD_TICKS : RAMP_STEP;
    localparam logic [DUTY_W-1:0] STEP_MAX = DUTY_W'(STEP_SAT);

    ramp_state_t       state_r;
    ramp_state_t       state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [DUTY_W-1:0] cur_duty_r;
    logic [DUTY_W-1:0] cur_duty_s;
    logic [DUTY_W-1:0] target_r;
    logic [DUTY_W-1:0] target_s;
    logic [DUTY_W-1:0] cnt_ext_s;
    logic [DUTY_W-1:0] diff_s;
    logic [DUTY_W-1:0] step_s;
    logic [DUTY_W-1:0] ramped_s;
    logic              up_s;
    logic              boundary_s;
    logic              pwm_r;
    logic              ready_r;
    logic              at_target_r;

    // Period counter: frozen at zero while disabled, advances on ticks.
    always_comb begin
        cnt_s      = cnt_r;
        boundary_s = tick & enable & (cnt_r == CNT_LAST);
        cnt_ext_s  = DUTY_W'(cnt_r);
        if (!enable) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (tick) begin
            if (cnt_r == CNT_LAST) begin
                cnt_s = {CNT_W{1'b0}};
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Next ramp value: bounded step toward target, computed on the magnitude
    // so neither direction can overshoot or wrap.
    always_comb begin
        up_s     = 1'b0;
        diff_s   = {DUTY_W{1'b0}};
        step_s   = {DUTY_W{1'b0}};
        ramped_s = cur_duty_r;
        if (target_r >= cur_duty_r) begin
            up_s   = 1'b1;
            diff_s = target_r - cur_duty_r;
        end else begin
            up_s   = 1'b0;
            diff_s = cur_duty_r - target_r;
        end
        if (diff_s < STEP_MAX) begin
            step_s = diff_s;
        end else begin
            step_s = STEP_MAX;
        end
        if (up_s) begin
            ramped_s = cur_duty_r + step_s;
        end else begin
            ramped_s = cur_duty_r - step_s;
        end
    end

    // FSM next state: accept a target in IDLE, apply steps at boundaries in RAMP.
    always_comb begin
        state_s    = state_r;
        target_s   = target_r;
        cur_duty_s = cur_duty_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_duty > DUTY_MAX) begin
                        target_s = DUTY_MAX;
                    end else begin
                        target_s = bus.req_duty;
                    end
                    state_s = RAMP;
                end else begin
                    state_s = IDLE;
                end
            end
            RAMP: begin
                if (boundary_s) begin
                    cur_duty_s = ramped_s;
                    if (ramped_s == target_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RAMP;
                    end
                end else begin
                    state_s = RAMP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; status flags are registered from the
    // next-state values so they track state/duty exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cur_duty_r  <= {DUTY_W{1'b0}};
            target_r    <= {DUTY_W{1'b0}};
            pwm_r       <= 1'b0;
            ready_r     <= 1'b1;
            at_target_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_duty_r  <= cur_duty_s;
            target_r    <= target_s;
            pwm_r       <= enable & (cnt_ext_s < cur_duty_r);
            ready_r     <= (state_s == IDLE);
            at_target_r <= (cur_duty_s == target_s);
        end
    end

    assign pwm           = pwm_r;
    assign at_target     = at_target_r;
    assign bus.req_ready = ready_r;

endmodule

// File: tb/tb_pwm_ramp.sv
// Randomized and scenario bench for pwm_ramp: two instances (step 1 and
// step 4, period 10) compared every clock against a behavioural model.
module tb_pwm_ramp;

    localparam int PT     = 10;
    localparam int DW     = 8;
    localparam int STEP_A = 1;
    localparam int STEP_B = 4;

    logic clk;
    logic reset;
    logic tick;
    logic enable;
    logic pwm_a;
    logic pwm_b;
    logic at_target_a;
    logic at_target_b;

    int checks;
    int failures;

    int m_cnt  [2];
    int m_cur  [2];
    int m_tgt  [2];
    bit m_busy [2];
    bit m_pwm  [2];
    int steps  [2];

    pwm_ramp_if #(.DUTY_W(DW)) bus_a ();
    pwm_ramp_if #(.DUTY_W(DW)) bus_b ();

    pwm_ramp #(.PERIOD_TICKS(PT), .DUTY_W(DW), .RAMP_STEP(STEP_A)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .bus       (bus_a.slave),
        .pwm       (pwm_a),
        .at_target (at_target_a)
    );

    pwm_ramp #(.PERIOD_TICKS(PT), .DUTY_W(DW), .RAMP_STEP(STEP_B)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .bus       (bus_b.slave),
        .pwm       (pwm_b),
        .at_target (at_target_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge of the specified behaviour.
    task automatic model_step(input int i, input bit rst, input bit tk, input bit en,
                              input bit v, input int d);
        bit boundary;
        int gap;
        int mag;
        if (rst) begin
            m_cnt[i]  = 0;
            m_cur[i]  = 0;
            m_tgt[i]  = 0;
            m_busy[i] = 1'b0;
            m_pwm[i]  = 1'b0;
        end else begin
            boundary = tk && en && (m_cnt[i] == PT - 1);
            m_pwm[i] = en && (m_cnt[i] < m_cur[i]);
            if (!en) m_cnt[i] = 0;
            else if (tk) m_cnt[i] = (m_cnt[i] + 1) % PT;
            if (!m_busy[i]) begin
                if (v) begin
                    m_tgt[i]  = (d > PT) ? PT : d;
                    m_busy[i] = 1'b1;
                end
            end else if (boundary) begin
                gap = m_tgt[i] - m_cur[i];
                mag = (gap < 0) ? -gap : gap;
                if (mag > steps[i]) mag = steps[i];
                m_cur[i] = m_cur[i] + ((gap < 0) ? -mag : mag);
                if (m_cur[i] == m_tgt[i]) m_busy[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        bit r;
        bit t;
        bit e;
        bit va;
        bit vb;
        int da;
        int db;
        r  = reset;
        t  = tick;
        e  = enable;
        va = bus_a.req_valid;
        vb = bus_b.req_valid;
        da = int'(bus_a.req_duty);
        db = int'(bus_b.req_duty);
        @(posedge clk);
        #1;
        model_step(0, r, t, e, va, da);
        model_step(1, r, t, e, vb, db);
        check_eq("pwm_a",    32'(pwm_a),           32'(m_pwm[0]));
        check_eq("pwm_b",    32'(pwm_b),           32'(m_pwm[1]));
        check_eq("ready_a",  32'(bus_a.req_ready), 32'(!m_busy[0]));
        check_eq("ready_b",  32'(bus_b.req_ready), 32'(!m_busy[1]));
        check_eq("attgt_a",  32'(at_target_a),     32'(m_cur[0] == m_tgt[0]));
        check_eq("attgt_b",  32'(at_target_b),     32'(m_cur[1] == m_tgt[1]));
    endtask

    task automatic request(input int da, input int db);
        bus_a.req_valid = 1'b1;
        bus_a.req_duty  = DW'(da);
        bus_b.req_valid = 1'b1;
        bus_b.req_duty  = DW'(db);
        cycle();
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(bus_a.req_ready && bus_b.req_ready)) begin
            cycle();
            k = k + 1;
        end
        check_eq("wait_idle", 32'(bus_a.req_ready && bus_b.req_ready), 32'd1);
    endtask

    // Steady state: any PT consecutive enabled ticks show exactly duty highs.
    task automatic measure(input int exp_a, input int exp_b);
        int ha;
        int hb;
        ha = 0;
        hb = 0;
        tick   = 1'b1;
        enable = 1'b1;
        cycle();
        repeat (PT) begin
            cycle();
            ha = ha + int'(pwm_a);
            hb = hb + int'(pwm_b);
        end
        check_eq("duty_hi_a", 32'(ha), 32'(exp_a));
        check_eq("duty_hi_b", 32'(hb), 32'(exp_b));
    endtask

    task automatic check_reset_values();
        check_eq("rst_pwm_a",   32'(pwm_a),           32'd0);
        check_eq("rst_pwm_b",   32'(pwm_b),           32'd0);
        check_eq("rst_ready_a", 32'(bus_a.req_ready), 32'd1);
        check_eq("rst_ready_b", 32'(bus_b.req_ready), 32'd1);
        check_eq("rst_attgt_a", 32'(at_target_a),     32'd1);
        check_eq("rst_attgt_b", 32'(at_target_b),     32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        steps[0] = STEP_A;
        steps[1] = STEP_B;
        reset    = 1'b1;
        tick     = 1'b1;
        enable   = 1'b1;
        bus_a.req_valid = 1'b0;
        bus_a.req_duty  = 8'd0;
        bus_b.req_valid = 1'b0;
        bus_b.req_duty  = 8'd0;
        cycle();
        cycle();
        check_reset_values();
        reset = 1'b0;

        // Basic ramp 0->3 (step 1) and 0->4 (single step).
        request(3, 4);
        wait_idle(200);
        measure(3, 4);

        // Over-range request clamps to full duty.
        request(15, 15);
        wait_idle(300);
        measure(PT, PT);

        // Enable gap mid-ramp 0->8.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        request(8, 8);
        for (int k = 0; k < 300 && m_cur[0] != 2; k++) cycle();
        enable = 1'b0;
        repeat (50) cycle();
        enable = 1'b1;
        wait_idle(300);
        measure(8, 8);

        // Requests while ramping are ignored.
        request(6, 2);
        bus_a.req_valid = 1'b1;
        bus_a.req_duty  = 8'd9;
        bus_b.req_valid = 1'b1;
        bus_b.req_duty  = 8'd9;
        repeat (12) cycle();
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        wait_idle(300);
        measure(6, 2);

        // Request equal to current duty.
        request(6, 2);
        wait_idle(100);
        measure(6, 2);

        // Reset mid-ramp together with tick and req_valid.
        request(0, 9);
        repeat (15) cycle();
        reset = 1'b1;
        tick  = 1'b1;
        bus_a.req_valid = 1'b1;
        bus_a.req_duty  = 8'd5;
        bus_b.req_valid = 1'b1;
        bus_b.req_duty  = 8'd5;
        cycle();
        check_reset_values();
        reset = 1'b0;
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        measure(0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick   = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 499) == 0);
            bus_a.req_valid = ($urandom_range(0, 3) == 0);
            bus_a.req_duty  = DW'($urandom_range(0, 20));
            bus_b.req_valid = ($urandom_range(0, 3) == 0);
            bus_b.req_duty  = DW'($urandom_range(0, 20));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 Parameter PERIOD_TICKS, default 200, sets the PWM period in time-base ticks (100 Hz at 20 kHz ticks).
REQ-002 Parameter DUTY_W, default 8, sets the duty/target width; PERIOD_TICKS SHALL be <= 2^DUTY_W - 1.
REQ-003 Parameter RAMP_STEP, default 1, sets the maximum duty change per PWM period, in ticks.
REQ-004 Port clk, input, 1, is the single clock; all logic is posedge clk.
REQ-005 Port reset, input, 1, is a synchronous, active-high reset.
REQ-006 Port tick, input, 1, is a one-clk-wide time-base strobe from the upstream tick generator.
REQ-007 Port enable, input, 1, gates the output; when low, pwm SHALL be 0 and the period counter SHALL be held at 0.
REQ-008 Port req_valid, input, 1, signals that req_duty holds a new target duty.
REQ-009 Port req_duty, input, DUTY_W, is the target duty in ticks high per period.
REQ-010 Port req_ready, output, 1, is high when a new target is accepted.
REQ-011 Port pwm, output, 1, is the registered PWM waveform.
REQ-012 Port at_target, output, 1, is high when the applied duty equals the target.

Function
REQ-013 The period counter cnt SHALL advance by 1 only on clk edges with tick=1 and enable=1, and wrap from PERIOD_TICKS-1 to 0.
REQ-014 A period boundary is a tick=1, enable=1 edge with cnt=PERIOD_TICKS-1.
REQ-015 pwm SHALL be registered as (enable && cnt < cur_duty), giving 1 clk latency from a cnt/cur_duty change to pwm.
REQ-016 cur_duty SHALL change only at a period boundary, so no period is truncated or glitched.
REQ-017 The FSM SHALL have two states, IDLE and RAMP; req_ready = (state==IDLE).
REQ-018 In IDLE, req_valid=1 SHALL load target <= min(req_duty, PERIOD_TICKS) and enter RAMP; a clamped request is not flagged.
REQ-019 In RAMP, at each period boundary cur_duty SHALL move toward target by min(RAMP_STEP, |target-cur_duty|), without overshoot or unsigned wrap.
REQ-020 The FSM SHALL return to IDLE on the edge where cur_duty becomes equal to target.
REQ-021 A request equal to cur_duty SHALL enter RAMP and return to IDLE at the next period boundary with no duty change.
REQ-022 req_valid during RAMP SHALL be ignored, with no queuing.
REQ-023 at_target SHALL equal (cur_duty==target) and be 1 in IDLE.
REQ-024 When enable=0 during RAMP, no period boundaries occur, so the ramp pauses; target is retained.
REQ-025 cur_duty=0 SHALL yield pwm constantly 0; cur_duty=PERIOD_TICKS SHALL yield pwm constantly 1 while enabled.

Reset
REQ-026 On reset=1, the block SHALL set cnt=0, cur_duty=0, target=0, state=IDLE, pwm=0, req_ready=1 and at_target=1 on the next edge.
REQ-027 Reset mid-ramp SHALL abandon the ramp; reset SHALL take priority over tick, enable and req_valid on the same edge.

Structure
REQ-028 Package pwm_ramp_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-029 No sub-module is required; the tick source is an external, separate instance, and cnt width SHALL be derived from PERIOD_TICKS by a clog2-style constant function.

Verification
REQ-030 Scenario: PERIOD_TICKS=10, tick=1 every clk, enable=1, request 4 with RAMP_STEP=10 -> after the next boundary, each period shows pwm high 4 clks and low 6 clks, and at_target=1.
REQ-031 Scenario: RAMP_STEP=1, from 0 request 3 -> pwm high 0,1,2,3 clks in consecutive periods; req_ready low for 3 periods, then high.
REQ-032 Scenario: request 15 with PERIOD_TICKS=10 -> target clamps to 10 and pwm is constantly high once ramped.
REQ-033 Scenario: ramping 0->8, drop enable for 50 clks at cur_duty=2, then restore -> pwm=0 and cur_duty=2 throughout the gap; the ramp resumes at 3.
REQ-034 Scenario: req_valid during RAMP with a different value -> ignored, and the original target is reached.
REQ-035 Scenario: reset asserted mid-ramp together with tick and req_valid -> all REQ-026 values on the next edge; the first period after reset has pwm=0.
